// File: rtl/array_mult_seq_ctrl.sv
// Sequencer that time-multiplexes one external HALF_W x HALF_W array multiplier
// to form a (2*HALF_W) x (2*HALF_W) unsigned product over four partial-product cycles.
module array_mult_seq_ctrl #(
  parameter int HALF_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*HALF_W-1:0]   in_a,
  input  logic [2*HALF_W-1:0]   in_b,
  output logic [HALF_W-1:0]     mul_a,
  output logic [HALF_W-1:0]     mul_b,
  input  logic [2*HALF_W-1:0]   mul_p,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [4*HALF_W-1:0]   res_p,
  output logic                  busy
);

  localparam int OW = 2 * HALF_W;
  localparam int PW = 4 * HALF_W;

  typedef enum logic [2:0] {
    IDLE,
    PP0,
    PP1,
    PP2,
    PP3,
    DONE
  } state_e;

  state_e          state_q;
  logic [OW-1:0]   a_q;
  logic [OW-1:0]   b_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   acc_d;
  logic [PW-1:0]   pp_shifted;
  logic [PW-1:0]   pp_ext;
  logic            in_ready_q;
  logic            busy_q;
  logic            res_valid_q;

  wire [HALF_W-1:0] a_lo = a_q[HALF_W-1:0];
  wire [HALF_W-1:0] a_hi = a_q[OW-1:HALF_W];
  wire [HALF_W-1:0] b_lo = b_q[HALF_W-1:0];
  wire [HALF_W-1:0] b_hi = b_q[OW-1:HALF_W];

  assign pp_ext = {{OW{1'b0}}, mul_p};

  // Operand select and partial-product alignment, decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves a latch.
    mul_a      = '0;
    mul_b      = '0;
    pp_shifted = '0;
    unique case (state_q)
      PP0: begin
        mul_a      = a_lo;
        mul_b      = b_lo;
        pp_shifted = pp_ext;
      end
      PP1: begin
        mul_a      = a_lo;
        mul_b      = b_hi;
        pp_shifted = pp_ext << HALF_W;
      end
      PP2: begin
        mul_a      = a_hi;
        mul_b      = b_lo;
        pp_shifted = pp_ext << HALF_W;
      end
      PP3: begin
        mul_a      = a_hi;
        mul_b      = b_hi;
        pp_shifted = pp_ext << OW;
      end
      default: ;
    endcase
  end

  // Cannot overflow: the largest full product still fits in PW bits.
  assign acc_d = acc_q + pp_shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= in_a;
            b_q        <= in_b;
            acc_q      <= '0;
            state_q    <= PP0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        PP0: begin
          acc_q   <= acc_d;
          state_q <= PP1;
        end
        PP1: begin
          acc_q   <= acc_d;
          state_q <= PP2;
        end
        PP2: begin
          acc_q   <= acc_d;
          state_q <= PP3;
        end
        PP3: begin
          acc_q       <= acc_d;
          state_q     <= DONE;
          res_valid_q <= 1'b1;
        end
        DONE: begin
          if (res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_p     = acc_q;

endmodule

// File: tb/tb_array_mult_seq_ctrl.sv
// Bench for array_mult_seq_ctrl: behavioural shared multiplier, scoreboard of a*b
// pushed on every accept and checked on every result handshake.
module tb_array_mult_seq_ctrl;

  localparam int HALF_W = 4;
  localparam int OW     = 2 * HALF_W;
  localparam int PW     = 4 * HALF_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [OW-1:0]     in_a;
  logic [OW-1:0]     in_b;
  logic [HALF_W-1:0] mul_a;
  logic [HALF_W-1:0] mul_b;
  logic [OW-1:0]     mul_p;
  logic              res_valid;
  logic              res_ready;
  logic [PW-1:0]     res_p;
  logic              busy;

  int            vectors     = 0;
  int            miscompares = 0;
  int            cycle_cnt   = 0;
  logic [PW-1:0] exp_q[$];

  array_mult_seq_ctrl #(.HALF_W(HALF_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // The shared combinational array multiplier that lives outside the block.
  assign mul_p = OW'(mul_a) * OW'(mul_b);

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Scoreboard: sampled mid-cycle, reflecting the handshakes the next rising edge will take.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(PW'(in_a) * PW'(in_b));
      if (res_valid && res_ready) begin
        logic [PW-1:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: res_p=%h with no pending operation", res_p);
        end else begin
          e = exp_q.pop_front();
          if (res_p !== e) begin
            miscompares++;
            $display("FAIL sb_result: res_p=%h expected %h", res_p, e);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All stimulus is applied 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands and returns just after the accepting edge; in_valid is left high.
  task automatic send(input logic [OW-1:0] a, input logic [OW-1:0] b);
    int n = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
    end
    tick();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 50) begin
      tick();
      n++;
    end
    if (!res_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL res_timeout: res_valid=%b expected 1", res_valid);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if ({in_ready, busy, res_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL %s_flags: {in_ready,busy,res_valid}=%b expected 100", tag, {in_ready, busy, res_valid});
    end
    vectors++;
    if (res_p !== '0) begin
      miscompares++;
      $display("FAIL %s_res_p: res_p=%h expected 0000", tag, res_p);
    end
    vectors++;
    if ({mul_a, mul_b} !== '0) begin
      miscompares++;
      $display("FAIL %s_mul: mul_a,mul_b=%h expected 00", tag, {mul_a, mul_b});
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
  endtask

  // Latency counted with the accepting edge as edge 1: DONE is entered on edge 5.
  task automatic test_zero_latency();
    int n;
    res_ready = 1'b1;
    send(8'h00, 8'h00);
    in_valid = 1'b0;
    wait_valid(n);
    vectors++;
    if (n + 1 !== 5) begin
      miscompares++;
      $display("FAIL zero_latency: res_valid after %0d edges expected 5", n + 1);
    end
    vectors++;
    if (res_p !== 16'h0000) begin
      miscompares++;
      $display("FAIL zero_res_p: res_p=%h expected 0000", res_p);
    end
    tick();
    vectors++;
    if ({res_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL zero_release: {res_valid,in_ready}=%b expected 01", {res_valid, in_ready});
    end
  endtask

  task automatic test_mul_seq(input logic [OW-1:0] a, input logic [OW-1:0] b,
                              input logic [31:0] seq, input logic [PW-1:0] expected);
    logic [7:0] pair;
    res_ready = 1'b1;
    send(a, b);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pair = seq[31-8*i -: 8];
      vectors++;
      if ({mul_a, mul_b} !== pair) begin
        miscompares++;
        $display("FAIL mul_seq_pp%0d: mul_a,mul_b=%h expected %h", i, {mul_a, mul_b}, pair);
      end
      tick();
    end
    vectors++;
    if (res_valid !== 1'b1 || res_p !== expected) begin
      miscompares++;
      $display("FAIL mul_seq_result: valid=%b res_p=%h expected valid=1 res_p=%h", res_valid, res_p, expected);
    end
    vectors++;
    if ({mul_a, mul_b} !== 8'h00) begin
      miscompares++;
      $display("FAIL mul_seq_done_mul: mul_a,mul_b=%h expected 00", {mul_a, mul_b});
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    res_ready = 1'b0;
    send(8'h12, 8'h34);
    in_valid = 1'b0;
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({res_valid, in_ready, busy} !== 3'b101 || res_p !== 16'h03A8) begin
        miscompares++;
        $display("FAIL backpressure_hold%0d: v/r/b=%b res_p=%h expected 101 03a8", i, {res_valid, in_ready, busy}, res_p);
      end
      tick();
    end
    // New operands and result handshake together in DONE: only the result completes.
    in_a      = 8'h21;
    in_b      = 8'h07;
    in_valid  = 1'b1;
    res_ready = 1'b1;
    tick();
    vectors++;
    if ({in_ready, busy, res_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL dual_handshake_idle: {in_ready,busy,res_valid}=%b expected 100", {in_ready, busy, res_valid});
    end
    tick();
    vectors++;
    if ({in_ready, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL dual_handshake_accept: {in_ready,busy}=%b expected 01", {in_ready, busy});
    end
    in_valid = 1'b0;
    wait_valid(n);
    vectors++;
    if (res_p !== 16'h00E7) begin
      miscompares++;
      $display("FAIL dual_handshake_result: res_p=%h expected 00e7", res_p);
    end
    tick();
  endtask

  task automatic test_ignore_busy();
    res_ready = 1'b0;
    send(8'h5A, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      vectors++;
      if ({busy, in_ready} !== 2'b10) begin
        miscompares++;
        $display("FAIL ignore_busy_flags%0d: {busy,in_ready}=%b expected 10", i, {busy, in_ready});
      end
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (res_valid !== 1'b1 || res_p !== 16'h1518) begin
      miscompares++;
      $display("FAIL ignore_busy_result: valid=%b res_p=%h expected valid=1 res_p=1518", res_valid, res_p);
    end
    res_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    res_ready = 1'b1;
    send(8'hAB, 8'hCD);
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid");
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h0F, 8'h10);
    in_valid = 1'b0;
    wait_valid(n);
    vectors++;
    if (res_p !== 16'h00F0) begin
      miscompares++;
      $display("FAIL reset_mid_next: res_p=%h expected 00f0", res_p);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    int last = 0;
    int now;
    in_valid  = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_a = 8'($urandom_range(0, 255));
      in_b = 8'($urandom_range(0, 255));
      n = 0;
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      if (!in_ready) begin
        vectors++;
        miscompares++;
        $display("FAIL b2b_timeout%0d: in_ready=%b expected 1", k, in_ready);
      end
      now = cycle_cnt;
      tick();
      if (k > 0) begin
        vectors++;
        if (now - last !== 6) begin
          miscompares++;
          $display("FAIL b2b_spacing%0d: %0d cycles between accepts expected 6", k, now - last);
        end
      end
      last = now;
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_drain: %0d results outstanding expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_mul_seq(8'hFF, 8'hFF, 32'hFF_FF_FF_FF, 16'hFE01);
    test_mul_seq(8'h12, 8'h34, 32'h24_23_14_13, 16'h03A8);
    test_backpressure();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
